// File: rtl/lf_enc_pkg.sv
// Shared encodings for the LF bit encoder: mode codes, FSM states and the
// per-half level rule for each line code.
package lf_enc_pkg;

  localparam logic [1:0] ENC_NRZ     = 2'd0;
  localparam logic [1:0] ENC_MANCH   = 2'd1;
  localparam logic [1:0] ENC_BIPHASE = 2'd2;
  // 2'd3 is reserved and falls through to NRZ in enc_level().

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FIRST_HALF  = 2'd1,
    ST_SECOND_HALF = 2'd2
  } state_t;

  // Line level for one half of a bit.
  //   b      : data bit being sent
  //   lvl    : biphase level for this bit (already toggled at bit start)
  //   second : 0 = first half, 1 = second half
  function automatic logic enc_level(input logic [1:0] mode,
                                     input logic       b,
                                     input logic       lvl,
                                     input logic       second);
    logic r;
    case (mode)
      ENC_MANCH:   r = second ? b : ~b;
      ENC_BIPHASE: r = second ? (b ? lvl : ~lvl) : lvl;
      default:     r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lf_half_timer.sv
// Half-bit timer: counts carrier ticks within the current half and flags the
// tick that completes it. Periods below 2 are clamped so each half lasts at
// least one tick; odd periods put the extra tick in the second half.
module lf_half_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_tick,
  input  logic             i_second,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_half_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_first;
  logic [CNT_W-1:0] w_second;
  logic [CNT_W-1:0] w_len;

  assign w_period   = (i_period < CNT_W'(2)) ? CNT_W'(2) : i_period;
  assign w_first    = w_period >> 1;
  assign w_second   = w_period - w_first;
  assign w_len      = i_second ? w_second : w_first;
  // The half ends on the tick that brings the count up to its length.
  assign o_half_end = i_run && i_tick && (r_cnt == w_len - CNT_W'(1));

  // Tick counter: held at zero when idle, cleared at every half boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (!i_run || o_half_end) r_cnt <= '0;
    else if (i_tick)               r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/lf_bit_encoder.sv
// LF transmit bit encoder: serialises bytes MSB first onto mod_out using NRZ,
// Manchester or biphase, with bit timing counted in carrier ticks. One byte
// is double-buffered so consecutive bytes stream without a gap.
module lf_bit_encoder
  import lf_enc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_tick,
  input  logic [CNT_W-1:0] bit_period,
  input  logic [1:0]       enc_mode,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             mod_out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_period;
  logic             r_lvl;
  logic             r_mod;
  logic             r_busy;
  logic             r_done;

  logic w_half_end;
  logic w_accept;
  logic w_load;
  logic w_last_end;
  logic w_reload;

  assign w_accept   = tx_valid && !r_hold_full;
  assign w_load     = (r_state == ST_IDLE) && r_hold_full;
  assign w_last_end = (r_state == ST_SECOND_HALF) && w_half_end && (r_bit_idx == 3'd7);
  // Only a byte already held before the last bit ends can extend the frame.
  assign w_reload   = w_last_end && r_hold_full;

  assign tx_ready = !r_hold_full;
  assign mod_out  = r_mod;
  assign busy     = r_busy;
  assign done     = r_done;

  lf_half_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (r_state != ST_IDLE),
    .i_tick     (cyc_tick),
    .i_second   (r_state == ST_SECOND_HALF),
    .i_period   (r_period),
    .o_half_end (w_half_end)
  );

  // Holding register: filled on handshake, emptied when moved to the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load || w_reload) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end
  end

  // Frame FSM: bit/half sequencing, registered modulation level and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_mode    <= ENC_NRZ;
      r_period  <= '0;
      r_lvl     <= 1'b0;
      r_mod     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_hold_full) begin
            // Mode and period are frozen here for the whole frame.
            r_shift   <= r_hold;
            r_bit_idx <= '0;
            r_mode    <= enc_mode;
            r_period  <= bit_period;
            r_lvl     <= ~r_lvl;
            r_mod     <= enc_level(enc_mode, r_hold[7], ~r_lvl, 1'b0);
            r_busy    <= 1'b1;
            r_state   <= ST_FIRST_HALF;
          end
        end
        ST_FIRST_HALF: begin
          if (w_half_end) begin
            r_mod   <= enc_level(r_mode, r_shift[7], r_lvl, 1'b1);
            r_state <= ST_SECOND_HALF;
          end
        end
        ST_SECOND_HALF: begin
          if (w_half_end) begin
            if (r_bit_idx != 3'd7) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_bit_idx <= r_bit_idx + 3'd1;
              r_lvl     <= ~r_lvl;
              r_mod     <= enc_level(r_mode, r_shift[6], ~r_lvl, 1'b0);
              r_state   <= ST_FIRST_HALF;
            end else if (r_hold_full) begin
              // Seamless continuation; biphase level carries over.
              r_shift   <= r_hold;
              r_bit_idx <= '0;
              r_lvl     <= ~r_lvl;
              r_mod     <= enc_level(r_mode, r_hold[7], ~r_lvl, 1'b0);
              r_state   <= ST_FIRST_HALF;
            end else begin
              r_lvl   <= 1'b0;
              r_mod   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
